// File: rtl/tea_pkg.sv
// Shared constants and types for the TEA encryption core: block, half-word and
// key widths, the sideband width, the default key-schedule constant, and the
// controller state type.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
  localparam int BLOCK_W = 64;
  localparam int HALF_W  = 32;
  localparam int KEY_W   = 128;
  localparam int LFSR_W  = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tea_state_e;

endpackage

// File: rtl/tea_if.sv
// Handshake bundle for the TEA encryption core: plaintext/key input channel,
// ciphertext output channel and the busy status flag.
// Optional feature macro: TEA_LFSR_SIDEBAND_EN adds the 31-bit LFSR sideband
// that travels alongside each block.
interface tea_if;

  logic                         in_valid;
  logic                         in_ready;
  logic [tea_pkg::BLOCK_W-1:0]  in_data;
  logic [tea_pkg::KEY_W-1:0]    key;
  logic                         out_valid;
  logic                         out_ready;
  logic [tea_pkg::BLOCK_W-1:0]  out_data;
  logic                         busy;
`ifdef TEA_LFSR_SIDEBAND_EN
  logic [tea_pkg::LFSR_W-1:0]   in_lfsr_state;
  logic [tea_pkg::LFSR_W-1:0]   out_lfsr_state;

  modport master (
    output in_valid, in_data, key, out_ready, in_lfsr_state,
    input  in_ready, out_valid, out_data, busy, out_lfsr_state
  );

  modport slave (
    input  in_valid, in_data, key, out_ready, in_lfsr_state,
    output in_ready, out_valid, out_data, busy, out_lfsr_state
  );
`else
  modport master (
    output in_valid, in_data, key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, key, out_ready,
    output in_ready, out_valid, out_data, busy
  );
`endif

endinterface

// File: rtl/tea_enc_round.sv
// One full TEA encryption cycle as pure combinational logic. v1 is mixed into
// v0 first, then the freshly updated v0 is mixed into v1. All arithmetic is
// modulo 2^32 with logical shifts.
module tea_enc_round
  import tea_pkg::*;
(
  input  logic [HALF_W-1:0] v0_i,
  input  logic [HALF_W-1:0] v1_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [HALF_W-1:0] sum_i,
  output logic [HALF_W-1:0] v0_o,
  output logic [HALF_W-1:0] v1_o
);

  logic [HALF_W-1:0] k0, k1, k2, k3;

  assign {k0, k1, k2, k3} = key_i;

  // Feistel mixing term shared by both half-rounds; carries drop off at 32 bits.
  function automatic logic [HALF_W-1:0] mix(input logic [HALF_W-1:0] v,
                                            input logic [HALF_W-1:0] ka,
                                            input logic [HALF_W-1:0] kb,
                                            input logic [HALF_W-1:0] s);
    logic [HALF_W-1:0] t_shl, t_sum, t_shr;
    t_shl = (v << 4) + ka;
    t_sum = v + s;
    t_shr = (v >> 5) + kb;
    return t_shl ^ t_sum ^ t_shr;
  endfunction

  assign v0_o = v0_i + mix(v1_i, k0, k1, sum_i);
  assign v1_o = v1_i + mix(v0_o, k2, k3, sum_i);

endmodule

// File: rtl/tea_encrypt_core.sv
// Iterative TEA block encryptor: accepts a 64-bit block and 128-bit key in
// IDLE, runs one full TEA cycle per clock for ROUNDS clocks, then holds the
// ciphertext in DONE until the consumer takes it.
// Optional feature macro: TEA_LFSR_SIDEBAND_EN carries a 31-bit LFSR state
// from accept to the ciphertext output unchanged.
module tea_encrypt_core
  import tea_pkg::*;
#(
  parameter int unsigned       ROUNDS = 32,
  parameter logic [HALF_W-1:0] DELTA  = TEA_DELTA
) (
  input logic  clk,
  input logic  rst,
  tea_if.slave bus_if
);

  // Seven bits covers the full legal range of 1..64 rounds.
  localparam int unsigned      CNT_W    = 7;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  tea_state_e        state_q, state_d;
  logic [HALF_W-1:0] v0_q, v0_d;
  logic [HALF_W-1:0] v1_q, v1_d;
  logic [HALF_W-1:0] sum_q, sum_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] rnd_v0, rnd_v1;
`ifdef TEA_LFSR_SIDEBAND_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
`endif

  tea_enc_round u_round (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .key_i (key_q),
    .sum_i (sum_q),
    .v0_o  (rnd_v0),
    .v1_o  (rnd_v1)
  );

  // Next-state: capture on accept, one round per RUN cycle, release on handshake.
  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
`ifdef TEA_LFSR_SIDEBAND_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus_if.in_valid) begin
          v0_d    = bus_if.in_data[BLOCK_W-1:HALF_W];
          v1_d    = bus_if.in_data[HALF_W-1:0];
          key_d   = bus_if.key;
          sum_d   = DELTA;
          cnt_d   = '0;
`ifdef TEA_LFSR_SIDEBAND_EN
          lfsr_d  = bus_if.in_lfsr_state;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        v0_d  = rnd_v0;
        v1_d  = rnd_v1;
        sum_d = sum_q + DELTA;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_RND) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus_if.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and visible datapath state; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
`ifdef TEA_LFSR_SIDEBAND_EN
      lfsr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
`ifdef TEA_LFSR_SIDEBAND_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Key register only loads on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  assign bus_if.in_ready  = (state_q == ST_IDLE);
  assign bus_if.busy      = (state_q == ST_RUN);
  assign bus_if.out_valid = (state_q == ST_DONE);
  assign bus_if.out_data  = {v0_q, v1_q};
`ifdef TEA_LFSR_SIDEBAND_EN
  assign bus_if.out_lfsr_state = lfsr_q;
`endif

endmodule

// File: tb/tb_tea_encrypt_core.sv
// Self-checking bench for tea_encrypt_core: a block-level reference model
// (whole-block TEA encrypt/decrypt plus a phase timeline) is compared with the
// DUT on every falling clock edge, alongside directed literal checks.
// Optional feature macro: TEA_LFSR_SIDEBAND_EN enables sideband checks.
module tb_tea_encrypt_core;

  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tea_if bus ();

  tea_encrypt_core #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int checks = 0;
  int errors = 0;

  // Whole-block reference encryption, straight from the TEA definition.
  function automatic logic [63:0] tea_enc(input logic [63:0] d, input logic [127:0] k);
    logic [31:0] v0, v1, sum, k0, k1, k2, k3;
    v0 = d[63:32]; v1 = d[31:0]; sum = 32'd0;
    {k0, k1, k2, k3} = k;
    for (int i = 0; i < ROUNDS; i++) begin
      sum = sum + DELTA;
      v0  = v0 + ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
      v1  = v1 + ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
    end
    return {v0, v1};
  endfunction

  // Chained single-round decrypt, sum running from ROUNDS*DELTA down to DELTA.
  function automatic logic [63:0] tea_dec(input logic [63:0] d, input logic [127:0] k);
    logic [31:0] v0, v1, sum, k0, k1, k2, k3;
    v0 = d[63:32]; v1 = d[31:0]; sum = DELTA * 32'(ROUNDS);
    {k0, k1, k2, k3} = k;
    for (int i = 0; i < ROUNDS; i++) begin
      v1  = v1 - ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
      v0  = v0 - ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
      sum = sum - DELTA;
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference timeline: IDLE accepts, RUN lasts ROUNDS cycles, DONE waits for out_ready.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_e;
  mphase_e      ph = M_IDLE;
  int           remain = 0;
  int           out_count = 0;
  logic [63:0]  exp_out = '0;
  logic [63:0]  exp_plain = '0;
  logic [127:0] exp_key = '0;
`ifdef TEA_LFSR_SIDEBAND_EN
  logic [30:0]  exp_lfsr = '0;
`endif
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = M_IDLE;
    end else begin
      case (ph)
        M_IDLE: if (bus.in_valid) begin
          exp_plain = bus.in_data;
          exp_key   = bus.key;
          exp_out   = tea_enc(bus.in_data, bus.key);
`ifdef TEA_LFSR_SIDEBAND_EN
          exp_lfsr  = bus.in_lfsr_state;
`endif
          remain    = ROUNDS;
          ph        = M_RUN;
        end
        M_RUN: begin
          remain--;
          if (remain == 0) ph = M_DONE;
        end
        M_DONE: if (bus.out_ready) begin
          ph = M_IDLE;
          out_count++;
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  // Compare process: DUT against the reference every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready",  64'(bus.in_ready),  64'(ph == M_IDLE));
      chk("busy",      64'(bus.busy),      64'(ph == M_RUN));
      chk("out_valid", 64'(bus.out_valid), 64'(ph == M_DONE));
      if (ph == M_DONE) begin
        chk("out_data", bus.out_data, exp_out);
        chk("decrypt_roundtrip", tea_dec(bus.out_data, exp_key), exp_plain);
`ifdef TEA_LFSR_SIDEBAND_EN
        chk("out_lfsr", 64'(bus.out_lfsr_state), 64'(exp_lfsr));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.in_data = {$urandom, $urandom};
    bus.key     = {$urandom, $urandom, $urandom, $urandom};
`ifdef TEA_LFSR_SIDEBAND_EN
    bus.in_lfsr_state = 31'($urandom);
`endif
  endtask

  initial begin
    int lat;
    int ov_seen;
    int start;
    int guard;
    int dut_acc[$];

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = '0; bus.key = '0;
`ifdef TEA_LFSR_SIDEBAND_EN
    bus.in_lfsr_state = '0;
`endif

    // Reset state, with in_valid high to show reset dominates.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    step(); step();
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_out_data",  bus.out_data,       64'd0);
`ifdef TEA_LFSR_SIDEBAND_EN
    chk("rst_lfsr", 64'(bus.out_lfsr_state), 64'd0);
`endif
    bus.in_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    // Pin the reference model to the published vector and to its inverse.
    chk("model_kat", tea_enc(64'd0, 128'd0), 64'h41EA3A0A_94BAA940);
    chk("model_inverse", tea_dec(tea_enc(64'h01234567_89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF),
                                 128'h00112233_44556677_8899AABB_CCDDEEFF), 64'h01234567_89ABCDEF);

    // Known answer: zero key and data, latency exactly ROUNDS cycles.
    step();
    bus.in_valid = 1'b1; bus.in_data = '0; bus.key = '0;
`ifdef TEA_LFSR_SIDEBAND_EN
    bus.in_lfsr_state = 31'h2AAAAAAA;
`endif
    step();
    bus.in_valid = 1'b0;
    rand_inputs();
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      step();
      lat++;
      rand_inputs();
    end
    chk("kat_latency", 64'(lat), 64'd32);
    chk("kat_data", bus.out_data, 64'h41EA3A0A_94BAA940);
`ifdef TEA_LFSR_SIDEBAND_EN
    chk("kat_lfsr", 64'(bus.out_lfsr_state), 64'h2AAAAAAA);
`endif

    // Stall in DONE for 10 cycles with a competing in_valid.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      step();
      chk("hold_data",      bus.out_data,       64'h41EA3A0A_94BAA940);
      chk("hold_in_ready",  64'(bus.in_ready),  64'd0);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("release_in_ready",  64'(bus.in_ready),  64'd1);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Reset during round 17 discards the block.
    rand_inputs();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rand_inputs();
      step();
    end
    chk("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_data", bus.out_data, 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) ov_seen++;
    end
    chk("mid_rst_discard", 64'(ov_seen), 64'd0);

    // Next block after the reset completes correctly.
    start = out_count;
    rand_inputs();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    guard = 0;
    while (out_count == start && guard < 100) begin
      step();
      guard++;
    end
    chk("post_rst_block", 64'(out_count - start), 64'd1);

    // Back-to-back: in_valid and out_ready held high.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 680; c++) begin
      if (bus.in_ready) dut_acc.push_back(c);
      rand_inputs();
      step();
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", 64'(dut_acc.size()), 64'd20);
    for (int i = 1; i < dut_acc.size(); i++) begin
      chk("b2b_gap", 64'(dut_acc[i] - dut_acc[i-1]), 64'(ROUNDS + 2));
    end
    step(); step(); step();

    // Randomized traffic: 1000 blocks with random valid/ready.
    start = out_count;
    guard = 0;
    while ((out_count - start) < 1000 && guard < 60000) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      rand_inputs();
      step();
      guard++;
    end
    chk("random_blocks", 64'(out_count - start), 64'd1000);

    bus.in_valid = 1'b0;
    step();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tea_encrypt_core.md
TEA_ENCRYPT_CORE -- requirements
Module: tea_encrypt_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, meaning the number of full TEA cycles per block (legal range 1..64).
REQ-002 SHALL have parameter DELTA, default 32'h9E3779B9, meaning the key-schedule constant added to sum each round.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  plaintext block and key are valid.
REQ-007 in_ready  out  1  core can accept a block.
REQ-008 in_data  in  64  plaintext; v0=[63:32], v1=[31:0].
REQ-009 key  in  128  k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-010 out_valid  out  1  ciphertext is valid.
REQ-011 out_ready  in  1  consumer accepts the ciphertext.
REQ-012 out_data  out  64  ciphertext; {v0,v1}.
REQ-013 busy  out  1  high in RUN state.
REQ-014 in_lfsr_state  in  31  sideband; present only with TEA_LFSR_SIDEBAND_EN.
REQ-015 out_lfsr_state  out  31  sideband; present only with TEA_LFSR_SIDEBAND_EN.

Function
REQ-016 States SHALL be IDLE, RUN and DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in RUN.
REQ-017 IDLE with in_valid=1 SHALL capture in_data and key, set sum=DELTA and round counter=0, then go to RUN.
REQ-018 Each RUN cycle SHALL apply one round: v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), then v1 += ((v0'<<4)+k2) ^ (v0'+sum) ^ ((v0'>>5)+k3), where v0' is the updated v0; sum += DELTA; counter += 1.
REQ-019 All additions SHALL be modulo 2^32 and shifts logical; carries SHALL be discarded.
REQ-020 RUN SHALL go to DONE on the edge that completes round ROUNDS; for an accept at edge N, out_valid SHALL rise after edge N+ROUNDS.
REQ-021 The captured key SHALL be used for all rounds; key and in_data changes after accept SHALL have no effect.
REQ-022 DONE SHALL hold out_data stable until out_valid&out_ready, then go to IDLE; in_ready reasserts the following cycle, giving throughput of one block per ROUNDS+2 cycles minimum.
REQ-023 in_valid during RUN or DONE SHALL be ignored and SHALL NOT be accepted.
REQ-024 The result SHALL be exactly invertible by the team's single-round TEA decrypt block chained ROUNDS times with sum from ROUNDS*DELTA down to DELTA.

Reset
REQ-025 rst=1 SHALL force IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, sum=0, counter=0 and out_lfsr_state=0, with priority over every other event.
REQ-026 rst asserted mid-RUN or mid-DONE SHALL discard the block without emitting it.

Configuration
REQ-027 With TEA_LFSR_SIDEBAND_EN defined, in_lfsr_state SHALL be captured on accept and presented unchanged on out_lfsr_state while out_valid=1.
REQ-028 Without TEA_LFSR_SIDEBAND_EN, both LFSR ports and their register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package tea_pkg SHALL hold TEA_DELTA, the block, half and key width constants, and the state enum type.
REQ-030 The round function SHALL be a combinational sub-module tea_enc_round (v0, v1, key, sum in; v0', v1' out), instantiated once.

Verification
REQ-031 key=0, in_data=0, ROUNDS=32 -> out_data=64'h41EA3A0A_94BAA940, with out_valid rising exactly 32 cycles after accept.
REQ-032 Random key and data, output fed through 32 chained decrypt rounds -> the original plaintext is recovered, checked over 1000 vectors.
REQ-033 out_ready held low 10 cycles in DONE -> out_data stable, in_ready=0, and a new in_valid is not accepted; release -> IDLE the next cycle.
REQ-034 rst pulsed at round 17 -> out_valid is never asserted for that block, and the next accepted block yields a correct result.
REQ-035 With TEA_LFSR_SIDEBAND_EN, in_lfsr_state=31'h2AAAAAAA at accept, changed during RUN -> out_lfsr_state=31'h2AAAAAAA in DONE.
REQ-036 Back-to-back in_valid held high with out_ready=1 -> a new accept every ROUNDS+2 cycles, and every output is correct.
